av_menu_overlay: RTL and testbench

- Parametrised successor to the single-box menu overlay.
- Draws an N-item vertical menu panel with border, row dividers and a highlighted cursor row.
- Owns the menu open/navigate/confirm state machine, driven by one-cycle button pulses.
- Sits between the button edge detectors and the pixel mixer. Outputs a flagged pixel (MSB = overlay-valid) plus a selection handshake to game control.

---
 rtl/av_menu_overlay_pkg.sv | 20 ++
 rtl/av_menu_overlay_fsm.sv | 104 ++++++++++
 rtl/av_menu_overlay.sv | 116 +++++++++++
 tb/tb_av_menu_overlay.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/av_menu_overlay_pkg.sv
// Shared definitions for the menu overlay: colour defaults, screen limits
// and the menu state encoding used by both the FSM and the pixel pipeline.
package av_pkg;

  localparam int COLOR_W = 12;

  localparam logic [COLOR_W-1:0] BG_DEFAULT     = 12'hDDD;
  localparam logic [COLOR_W-1:0] HL_DEFAULT     = 12'hF80;
  localparam logic [COLOR_W-1:0] BORDER_DEFAULT = 12'h222;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  typedef enum logic [1:0] {
    HIDDEN  = 2'd0,
    OPEN    = 2'd1,
    CONFIRM = 2'd2
  } menu_state_t;

endpackage

// File: rtl/av_menu_overlay_fsm.sv
// Menu open/navigate/confirm state machine with wrapping cursor, confirm
// frame counter and the one-cycle selection handshake to game control.
module av_menu_fsm
  import av_pkg::*;
#(
  parameter int N_ITEMS        = 4,
  parameter int CONFIRM_FRAMES = 16,
  parameter int BLINK_LOG2     = 2
) (
  input  logic                       clk65,
  input  logic                       rst,
  input  logic                       menu_toggle,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_select,
  input  logic                       new_frame,
  output menu_state_t                state,
  output logic [$clog2(N_ITEMS)-1:0] cursor,
  output logic                       highlight,
  output logic                       menu_active,
  output logic                       sel_valid,
  output logic [$clog2(N_ITEMS)-1:0] sel_index
);

  localparam int IDX_W   = $clog2(N_ITEMS);
  localparam int CNT_RAW = $clog2(CONFIRM_FRAMES + 1);
  // The counter must also be wide enough to expose the blink bit.
  localparam int CNT_W   = (CNT_RAW > BLINK_LOG2) ? CNT_RAW : BLINK_LOG2 + 1;

  localparam logic [IDX_W-1:0] LAST_ITEM = IDX_W'(N_ITEMS - 1);
  localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(CONFIRM_FRAMES);

  menu_state_t      state_n;
  logic [IDX_W-1:0] cursor_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic             sel_valid_n;
  logic [IDX_W-1:0] sel_index_n;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk65) begin
    if (rst) begin
      state       <= HIDDEN;
      cursor      <= '0;
      frame_cnt   <= '0;
      sel_valid   <= 1'b0;
      sel_index   <= '0;
      menu_active <= 1'b0;
    end else begin
      state       <= state_n;
      cursor      <= cursor_n;
      frame_cnt   <= frame_cnt_n;
      sel_valid   <= sel_valid_n;
      sel_index   <= sel_index_n;
      menu_active <= (state_n != HIDDEN);
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    cursor_n    = cursor;
    frame_cnt_n = frame_cnt;
    sel_valid_n = 1'b0;
    sel_index_n = sel_index;
    unique case (state)
      HIDDEN: begin
        if (menu_toggle) begin
          state_n  = OPEN;
          cursor_n = '0;
        end
      end
      OPEN: begin
        if (btn_select) begin
          state_n     = CONFIRM;
          frame_cnt_n = '0;
        end else if (menu_toggle) begin
          state_n = HIDDEN;
        end else if (btn_up && !btn_down) begin
          cursor_n = (cursor == '0) ? LAST_ITEM : cursor - 1'b1;
        end else if (btn_down && !btn_up) begin
          cursor_n = (cursor == LAST_ITEM) ? '0 : cursor + 1'b1;
        end
      end
      CONFIRM: begin
        if (new_frame) begin
          frame_cnt_n = frame_cnt + 1'b1;
          if (frame_cnt_n == DONE_CNT) begin
            sel_valid_n = 1'b1;
            sel_index_n = cursor;
            state_n     = HIDDEN;
          end
        end
      end
      default: state_n = HIDDEN;
    endcase
  end

  // The chosen row flashes during CONFIRM; it is solid while navigating.
  assign highlight = (state == OPEN) ||
                     ((state == CONFIRM) && !frame_cnt[BLINK_LOG2]);

endmodule

// File: rtl/av_menu_overlay.sv
// N-item vertical menu overlay: 2-stage pixel pipeline (geometry, then colour
// mux) driven by the menu FSM. Output MSB flags an opaque overlay pixel.
module av_menu_overlay
  import av_pkg::*;
#(
  parameter int                     N_ITEMS        = 4,
  parameter int                     COLOR_W        = av_pkg::COLOR_W,
  parameter int                     START_X        = 100,
  parameter int                     START_Y        = 50,
  parameter int                     WIDTH          = 800,
  parameter int                     LOG2_ITEM_H    = 6,
  parameter int                     BORDER         = 4,
  parameter logic [COLOR_W-1:0]     BG_COLOR       = BG_DEFAULT,
  parameter logic [COLOR_W-1:0]     HL_COLOR       = HL_DEFAULT,
  parameter logic [COLOR_W-1:0]     BORDER_COLOR   = BORDER_DEFAULT,
  parameter int                     CONFIRM_FRAMES = 16,
  parameter int                     BLINK_LOG2     = 2
) (
  input  logic                       clk65,
  input  logic                       rst,
  input  logic                       menu_toggle,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_select,
  input  logic                       new_frame,
  input  logic [10:0]                hcount,
  input  logic [9:0]                 vcount,
  output logic [COLOR_W:0]           menu_pixel,
  output logic                       menu_active,
  output logic                       sel_valid,
  output logic [$clog2(N_ITEMS)-1:0] sel_index
);

  localparam int IDX_W = $clog2(N_ITEMS);

  localparam logic [10:0] X0      = 11'(START_X);
  localparam logic [10:0] X1      = 11'(START_X + WIDTH);
  localparam logic [10:0] Y0      = 11'(START_Y);
  localparam logic [10:0] PANEL_H = 11'(N_ITEMS << LOG2_ITEM_H);
  localparam logic [10:0] Y1      = 11'(START_Y + (N_ITEMS << LOG2_ITEM_H));
  localparam logic [10:0] BORD    = 11'(BORDER);
  localparam logic [10:0] X_FAR   = 11'(WIDTH - BORDER);
  localparam logic [10:0] Y_FAR   = 11'((N_ITEMS << LOG2_ITEM_H) - BORDER);
  localparam logic [LOG2_ITEM_H-1:0] ROW_BORD = LOG2_ITEM_H'(BORDER);

  menu_state_t      state;
  logic [IDX_W-1:0] cursor;
  logic             highlight;

  av_menu_fsm #(
    .N_ITEMS       (N_ITEMS),
    .CONFIRM_FRAMES(CONFIRM_FRAMES),
    .BLINK_LOG2    (BLINK_LOG2)
  ) u_fsm (
    .clk65      (clk65),
    .rst        (rst),
    .menu_toggle(menu_toggle),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_select (btn_select),
    .new_frame  (new_frame),
    .state      (state),
    .cursor     (cursor),
    .highlight  (highlight),
    .menu_active(menu_active),
    .sel_valid  (sel_valid),
    .sel_index  (sel_index)
  );

  // Stage 1: panel geometry. Offsets wrap when outside the panel, but they
  // are only consumed when in_panel is set.
  logic [10:0] vcount_ext, rel_x, rel_y;
  logic        in_panel_c, edge_c;

  assign vcount_ext = {1'b0, vcount};
  assign rel_x      = hcount - X0;
  assign rel_y      = vcount_ext - Y0;
  assign in_panel_c = (hcount >= X0) && (hcount < X1) &&
                      (vcount_ext >= Y0) && (vcount_ext < Y1) && (PANEL_H != '0);
  // A row's top band doubles as the top border for row 0.
  assign edge_c     = (rel_x < BORD) || (rel_x >= X_FAR) || (rel_y >= Y_FAR) ||
                      (rel_y[LOG2_ITEM_H-1:0] < ROW_BORD);

  logic             s1_in_panel, s1_edge;
  logic [IDX_W-1:0] s1_row;

  always_ff @(posedge clk65) begin
    if (rst) begin
      s1_in_panel <= 1'b0;
      s1_edge     <= 1'b0;
      s1_row      <= '0;
    end else begin
      s1_in_panel <= in_panel_c;
      s1_edge     <= edge_c;
      s1_row      <= IDX_W'(rel_y >> LOG2_ITEM_H);
    end
  end

  // Stage 2: colour mux against the live FSM state.
  logic [COLOR_W:0] pixel_c;

  always_comb begin
    pixel_c = '0;
    if (s1_in_panel && (state != HIDDEN)) begin
      if (s1_edge)                             pixel_c = {1'b1, BORDER_COLOR};
      else if ((s1_row == cursor) && highlight) pixel_c = {1'b1, HL_COLOR};
      else                                     pixel_c = {1'b1, BG_COLOR};
    end
  end

  always_ff @(posedge clk65) begin
    if (rst) menu_pixel <= '0;
    else     menu_pixel <= pixel_c;
  end

endmodule

// File: tb/tb_av_menu_overlay.sv
// Self-checking bench for av_menu_overlay: pixel vector table, directed
// multi-cycle sequences and a random run against a behavioural menu model.
module tb_av_menu_overlay;

  localparam int N = 4;

  logic        clk65 = 1'b0;
  logic        rst, menu_toggle, btn_up, btn_down, btn_select, new_frame;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [12:0] menu_pixel;
  logic        menu_active, sel_valid;
  logic [1:0]  sel_index;

  always #5 clk65 = ~clk65;

  av_menu_overlay dut (
    .clk65      (clk65),
    .rst        (rst),
    .menu_toggle(menu_toggle),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_select (btn_select),
    .new_frame  (new_frame),
    .hcount     (hcount),
    .vcount     (vcount),
    .menu_pixel (menu_pixel),
    .menu_active(menu_active),
    .sel_valid  (sel_valid),
    .sel_index  (sel_index)
  );

  int errors = 0;
  int checks = 0;

  // Model: 0 = hidden, 1 = open, 2 = confirming
  int m_state, m_cursor, m_frames, m_sel;

  typedef struct {
    int          h;
    int          v;
    logic [12:0] px;
  } pix_vec_t;

  pix_vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk65);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_cursor = 0; m_frames = 0; m_sel = 0;
  endtask

  function automatic logic [12:0] pix_model(input int h, input int v);
    int rx, ry, row;
    if (m_state == 0 || h < 100 || h >= 900 || v < 50 || v >= 50 + N * 64) return 13'h0;
    rx  = h - 100;
    ry  = v - 50;
    row = ry / 64;
    if (rx < 4 || rx >= 796 || ry >= N * 64 - 4 || (ry % 64) < 4) return 13'h1222;
    if (row == m_cursor && (m_state == 1 || ((m_frames / 4) % 2) == 0)) return 13'h1F80;
    return 13'h1DDD;
  endfunction

  // One clock with the given button pulses; checks the handshake every cycle.
  task automatic press(input bit tog, input bit up, input bit dn, input bit sel, input bit nf);
    bit was_active, exp_sv;
    was_active  = (m_state != 0);
    menu_toggle = tog; btn_up = up; btn_down = dn; btn_select = sel; new_frame = nf;
    step();
    menu_toggle = 0; btn_up = 0; btn_down = 0; btn_select = 0; new_frame = 0;
    exp_sv = 0;
    case (m_state)
      0: if (tog) begin m_state = 1; m_cursor = 0; end
      1: begin
        if (sel) begin m_state = 2; m_frames = 0; end
        else if (tog) m_state = 0;
        else if (up && !dn) m_cursor = (m_cursor + N - 1) % N;
        else if (dn && !up) m_cursor = (m_cursor + 1) % N;
      end
      default: if (nf) begin
        m_frames++;
        if (m_frames == 16) begin exp_sv = 1; m_sel = m_cursor; m_state = 0; end
      end
    endcase
    check("sel_valid", sel_valid, exp_sv);
    check("sel_index", sel_index, m_sel);
    if (was_active == (m_state != 0)) check("menu_active", menu_active, m_state != 0);
  endtask

  task automatic idle();
    press(0, 0, 0, 0, 0);
  endtask

  task automatic check_pix(input int h, input int v, input logic [12:0] exp, input string name);
    hcount = 11'(h);
    vcount = 10'(v);
    idle();
    idle();
    check(name, menu_pixel, exp);
  endtask

  initial begin
    rst = 1; menu_toggle = 0; btn_up = 0; btn_down = 0; btn_select = 0; new_frame = 0;
    hcount = 11'd500; vcount = 10'd100;
    model_reset();

    tbl[0]  = '{500, 100, 13'h1F80};
    tbl[1]  = '{500, 150, 13'h1DDD};
    tbl[2]  = '{50,  100, 13'h0000};
    tbl[3]  = '{101, 100, 13'h1222};
    tbl[4]  = '{500, 115, 13'h1222};
    tbl[5]  = '{500, 118, 13'h1DDD};
    tbl[6]  = '{99,  100, 13'h0000};
    tbl[7]  = '{100, 100, 13'h1222};
    tbl[8]  = '{103, 100, 13'h1222};
    tbl[9]  = '{104, 100, 13'h1F80};
    tbl[10] = '{895, 100, 13'h1F80};
    tbl[11] = '{896, 100, 13'h1222};
    tbl[12] = '{899, 100, 13'h1222};
    tbl[13] = '{900, 100, 13'h0000};
    tbl[14] = '{500, 49,  13'h0000};
    tbl[15] = '{500, 53,  13'h1222};
    tbl[16] = '{500, 54,  13'h1F80};
    tbl[17] = '{500, 301, 13'h1DDD};
    tbl[18] = '{500, 302, 13'h1222};
    tbl[19] = '{500, 306, 13'h0000};

    // Reset state
    step(); step();
    check("reset menu_pixel", menu_pixel, 13'h0);
    check("reset menu_active", menu_active, 1'b0);
    check("reset sel_valid", sel_valid, 1'b0);
    check("reset sel_index", sel_index, 2'd0);
    rst = 0;

    // Open; geometry table with cursor on row 0
    press(1, 0, 0, 0, 0);
    idle();
    check("open menu_active", menu_active, 1'b1);
    for (int i = 0; i < 20; i++)
      check_pix(tbl[i].h, tbl[i].v, tbl[i].px, $sformatf("pix_tbl[%0d]", i));

    // Cursor wrap and simultaneous up+down
    press(0, 1, 0, 0, 0);
    check_pix(500, 260, 13'h1F80, "wrap_up row3");
    check_pix(500, 100, 13'h1DDD, "wrap_up row0 cleared");
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 1, 1, 0, 0);
    check_pix(500, 150, 13'h1F80, "up+down keeps row1");

    // Buttons ignored while hidden
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 1, 0);
    check_pix(500, 150, 13'h0, "hidden pixel");
    check("hidden menu_active", menu_active, 1'b0);

    // Confirm row 2, toggle during confirm ignored, 16 frames of blinking
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      check_pix(500, 200, (((k / 4) % 2) == 0) ? 13'h1F80 : 13'h1DDD,
                $sformatf("blink frame %0d", k));
      press(0, 0, 0, 0, 1);
    end
    idle();
    check("after confirm menu_active", menu_active, 1'b0);
    check("after confirm sel_index", sel_index, 2'd2);
    check_pix(500, 200, 13'h0, "after confirm pixel row2");
    check_pix(500, 100, 13'h0, "after confirm pixel row0");

    // select+toggle together in OPEN confirms
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 1, 0);
    check_pix(500, 100, 13'h1F80, "sel+tog confirming");
    check("sel+tog menu_active", menu_active, 1'b1);

    // Reset after 5 confirm frames: no selection, everything cleared
    for (int k = 0; k < 5; k++) press(0, 0, 0, 0, 1);
    rst = 1;
    step();
    rst = 0;
    model_reset();
    check("mid-confirm reset sel_valid", sel_valid, 1'b0);
    check("mid-confirm reset sel_index", sel_index, 2'd0);
    check("mid-confirm reset menu_active", menu_active, 1'b0);
    check_pix(500, 100, 13'h0, "mid-confirm reset pixel");
    for (int k = 0; k < 15; k++) press(0, 0, 0, 0, 1);
    press(1, 0, 0, 0, 0);
    check_pix(500, 100, 13'h1F80, "reopen cursor 0");

    // Random run against the model
    for (int it = 0; it < 3000; it++) begin
      hcount = 11'($urandom_range(0, 1023));
      vcount = 10'($urandom_range(0, 767));
      press($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      if ((it % 8) == 0) begin
        int h, v;
        h = $urandom_range(80, 920);
        v = $urandom_range(30, 330);
        check_pix(h, v, pix_model(h, v), $sformatf("rand pix (%0d,%0d)", h, v));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
